// File: rtl/load_store_unit.sv
// Sequences one load/store at a time onto the memory's single port.
// Ports: req_* valid/ready request in, resp_* one-cycle completion out, mem_* memory port.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, ISSUE, SPLIT, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, buf_q;
    logic [2:0]  funct3_q;
    logic        write_q, err_q, split_q;
    logic [1:0]  k_q, last_k, cap_idx;
    logic        legal, misaligned, accept, cap_en;
    logic [31:0] byte_addr;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        legal = 1'b0;
        if (req_write) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001)
                 || (req_funct3 == 3'b010);
        end else begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001)
                 || (req_funct3 == 3'b010) || (req_funct3 == 3'b100)
                 || (req_funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes size for every legal access: 00 byte, 01 half, 10 word
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                     || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    assign last_k    = funct3_q[1] ? 2'd3 : 2'd1;
    assign byte_addr = addr_q + {30'd0, k_q};

    // Read data lags the address by one cycle: in SPLIT byte k-1 arrives,
    // in WAIT the final byte k arrives.
    assign cap_idx = (state == WAIT) ? k_q : k_q - 2'd1;
    assign cap_en  = split_q && !write_q
                  && (((state == SPLIT) && (k_q != 2'd0)) || (state == WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
            k_q      <= 2'd0;
            buf_q    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                write_q  <= req_write;
                err_q    <= !legal;
                split_q  <= legal && misaligned;
                k_q      <= 2'd0;
                buf_q    <= 32'd0;
            end
            if ((state == SPLIT) && (k_q != last_k))
                k_q <= k_q + 2'd1;
            if (cap_en)
                buf_q[{cap_idx, 3'b000} +: 8] <= mem_read_data[7:0];
        end
    end

    always_comb begin
        state_nxt         = state;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        resp_err          = 1'b0;
        resp_rdata        = 32'd0;
        mem_write         = 1'b0;
        mem_funct3        = 3'b010;
        mem_write_address = 32'd0;
        mem_write_data    = 32'd0;
        mem_read_address  = 32'd0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!legal)         state_nxt = RESP;
                    else if (misaligned) state_nxt = SPLIT;
                    else                state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_write         = write_q;
                mem_funct3        = funct3_q;
                mem_write_address = addr_q;
                mem_read_address  = addr_q;
                mem_write_data    = wdata_q;
                state_nxt         = write_q ? RESP : WAIT;
            end
            SPLIT: begin
                mem_write         = write_q;
                mem_funct3        = write_q ? 3'b000 : 3'b100;
                mem_write_address = byte_addr;
                mem_read_address  = byte_addr;
                mem_write_data    = {24'd0, wdata_q[{k_q, 3'b000} +: 8]};
                if (k_q == last_k)
                    state_nxt = write_q ? RESP : WAIT;
            end
            WAIT: begin
                if (split_q) begin
                    state_nxt = RESP;
                end else begin
                    // memory has already extended the aligned result
                    resp_valid = 1'b1;
                    resp_rdata = mem_read_data;
                    state_nxt  = IDLE;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nxt  = IDLE;
                if (!err_q && !write_q && split_q) begin
                    case (funct3_q)
                        3'b001:  resp_rdata = {{16{buf_q[15]}}, buf_q[15:0]};
                        3'b101:  resp_rdata = {16'd0, buf_q[15:0]};
                        default: resp_rdata = buf_q;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory
// model and a byte-level reference model of RV32I load/store semantics.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_write(mem_write),
        .mem_funct3(mem_funct3), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b100:  return {24'd0, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b101:  return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // memory block: registered read, byte-addressed writes
    logic [7:0]  mem [logic [31:0]];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'd0, pl_data = 32'd0;

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        mem_read_data <= ext(mem_funct3, {mb(mem_read_address + 32'd3),
            mb(mem_read_address + 32'd2), mb(mem_read_address + 32'd1),
            mb(mem_read_address)});
        if (pl_en)
            for (int i = 0; i < 4; i++)
                mem[pl_addr + 32'(i)] = pl_data[8*i +: 8];
        if (mem_write) begin
            mem[mem_write_address] = mem_write_data[7:0];
            if (mem_funct3 != 3'b000)
                mem[mem_write_address + 32'd1] = mem_write_data[15:8];
            if (mem_funct3 == 3'b010) begin
                mem[mem_write_address + 32'd2] = mem_write_data[23:16];
                mem[mem_write_address + 32'd3] = mem_write_data[31:24];
            end
        end
    end

    // reference model
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        return ext(f3, {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)});
    endfunction

    function automatic bit legal(input logic w, input logic [2:0] f3);
        if (w) return f3 inside {3'b000, 3'b001, 3'b010};
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic int exp_lat(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        nbytes = (f3[1:0] == 2'b10) ? 4 : (f3[1:0] == 2'b01) ? 2 : 1;
        if (!legal(w, f3)) return 1;
        if ((a % nbytes) == 0) return 2;
        return w ? nbytes + 1 : nbytes + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] tr_ra [16];
    logic [31:0] tr_wa [16];
    logic [31:0] tr_wd [16];
    logic [2:0]  tr_f3 [16];
    logic        tr_we [16];
    int          writes_seen, res_lat;
    logic [31:0] res_rd;
    logic        res_err;

    task automatic access(input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bit done;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom); req_write = 1'($urandom);
        res_lat = -1; res_rd = 'x; res_err = 1'bx;
        writes_seen = 0; done = 0; n = 1;
        while (!done && n <= 12) begin
            tr_ra[n] = mem_read_address; tr_wa[n] = mem_write_address;
            tr_wd[n] = mem_write_data; tr_f3[n] = mem_funct3;
            tr_we[n] = mem_write;
            if (mem_write) writes_seen++;
            if (resp_valid) begin
                res_lat = n; res_rd = resp_rdata; res_err = resp_err; done = 1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        @(posedge clk); #1;
        chk("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] erd;
        erd = 32'd0;
        if (legal(w, f3) && !w) erd = ref_load(f3, a);
        access(w, f3, a, wd);
        chk({tag, "_lat"}, 32'(res_lat), 32'(exp_lat(w, f3, a)));
        chk({tag, "_rdata"}, res_rd, erd);
        chk({tag, "_err"}, 32'(res_err), 32'(!legal(w, f3)));
        if (!w || !legal(w, f3)) chk({tag, "_nowrite"}, 32'(writes_seen), 32'd0);
        if (w && legal(w, f3)) begin
            ref_mem[a] = wd[7:0];
            if (f3 != 3'b000) ref_mem[a + 32'd1] = wd[15:8];
            if (f3 == 3'b010) begin
                ref_mem[a + 32'd2] = wd[23:16];
                ref_mem[a + 32'd3] = wd[31:24];
            end
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        preload(32'h100, 32'h44332211);
        preload(32'h104, 32'h88776655);
        preload(32'h108, 32'h000000F0);
        preload(32'hFFFFFFFC, 32'hDDCCBBAA);
        preload(32'h0, 32'h00001122);
        @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_f3", 32'(mem_funct3), 32'd2);
        @(negedge clk); rst_n = 1'b1;

        // 1. aligned lw
        run("lw100", 1'b0, 3'b010, 32'h100, 32'd0);
        chk("lw100_val", res_rd, 32'h44332211);
        chk("lw100_addr", tr_ra[1], 32'h100);
        chk("lw100_f3", 32'(tr_f3[1]), 32'd2);
        chk("lw100_wait_addr", tr_ra[2], 32'd0);

        // 2. misaligned lw
        run("lw101", 1'b0, 3'b010, 32'h101, 32'd0);
        chk("lw101_val", res_rd, 32'h55443322);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lw101_addr%0d", k), tr_ra[1+k], 32'h101 + 32'(k));
            chk($sformatf("lw101_f3_%0d", k), 32'(tr_f3[1+k]), 32'd4);
        end

        // 3. halfword loads
        run("lh106", 1'b0, 3'b001, 32'h106, 32'd0);
        chk("lh106_val", res_rd, 32'hFFFF8877);
        run("lh107", 1'b0, 3'b001, 32'h107, 32'd0);
        chk("lh107_val", res_rd, 32'hFFFFF088);
        run("lhu107", 1'b0, 3'b101, 32'h107, 32'd0);
        chk("lhu107_val", res_rd, 32'h0000F088);

        // 4. misaligned sw then read back
        run("sw202", 1'b1, 3'b010, 32'h202, 32'hA1B2C3D4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sw202_we%0d", k), 32'(tr_we[1+k]), 32'd1);
            chk($sformatf("sw202_addr%0d", k), tr_wa[1+k], 32'h202 + 32'(k));
        end
        chk("sw202_d0", tr_wd[1], 32'hD4);
        chk("sw202_d1", tr_wd[2], 32'hC3);
        chk("sw202_d2", tr_wd[3], 32'hB2);
        chk("sw202_d3", tr_wd[4], 32'hA1);
        run("lw200", 1'b0, 3'b010, 32'h200, 32'd0);
        chk("lw200_val", res_rd, 32'hC3D40000);
        run("lw204", 1'b0, 3'b010, 32'h204, 32'd0);
        chk("lw204_val", res_rd, 32'h0000A1B2);

        // 5. illegal funct3
        run("ld011", 1'b0, 3'b011, 32'h100, 32'd0);
        chk("ld011_noaddr", tr_ra[1], 32'd0);
        chk("ld011_f3", 32'(tr_f3[1]), 32'd2);
        run("st100", 1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);

        // 6a. reset during a split store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h301; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_sw_b0_addr", mem_write_address, 32'h301);
        chk("rst_sw_b0_we", 32'(mem_write), 32'd1);
        @(posedge clk); #1;
        chk("rst_sw_b1_addr", mem_write_address, 32'h302);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_sw_no_we", 32'(mem_write), 32'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) chk("rst_sw_ready", 32'(req_ready), 32'd1);
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rst_sw_no_resp", 32'(seen), 32'd0);
        ref_mem[32'h301] = 8'h44;
        ref_mem[32'h302] = 8'h33;
        run("lw300", 1'b0, 3'b010, 32'h300, 32'd0);
        chk("lw300_val", res_rd, 32'h00334400);
        run("lw304", 1'b0, 3'b010, 32'h304, 32'd0);
        chk("lw304_val", res_rd, 32'h00000000);

        // 6b. address wrap
        run("lwwrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'd0);
        chk("lwwrap_val", res_rd, 32'h1122DDCC);
        chk("lwwrap_a0", tr_ra[1], 32'hFFFFFFFE);
        chk("lwwrap_a1", tr_ra[2], 32'hFFFFFFFF);
        chk("lwwrap_a2", tr_ra[3], 32'h00000000);
        chk("lwwrap_a3", tr_ra[4], 32'h00000001);

        // randomized accesses against the reference model
        for (int i = 0; i < 80; i++) begin
            logic w;
            logic [2:0] f3;
            w = 1'($urandom);
            f3 = 3'($urandom);
            run($sformatf("rnd%0d", i), w, f3,
                32'h100 + 32'($urandom_range(0, 31)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
